// File: rtl/npm_mc.sv
// NPM_MC: round-robin multi-channel AXI4 burst master for NP-core requesters.
// Optional NPM_MC_4K_SPLIT_EN additionally stops bursts at 4 KB address boundaries.
module npm_mc #(
   parameter int NCH  = 4,
   parameter int DW   = 64,
   parameter int MAXB = 256
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NCH-1:0]    req,
   input  logic [NCH-1:0]    rwn,
   input  logic [32*NCH-1:0] adr,
   input  logic [32*NCH-1:0] len,
   input  logic [DW*NCH-1:0] wdt,
   output logic [NCH-1:0]    gnt,
   output logic [NCH-1:0]    ack,
   output logic [NCH-1:0]    done,
   output logic [NCH-1:0]    err,
   output logic [DW-1:0]     rdt,
   output logic [31:0]       awaddr,
   output logic [7:0]        awlen,
   output logic              awvalid,
   input  logic              awready,
   output logic [3:0]        awid,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic [3:0]        awcache,
   output logic              awlock,
   output logic [2:0]        awprot,
   output logic [3:0]        awqos,
   output logic [3:0]        awregion,
   output logic [31:0]       araddr,
   output logic [7:0]        arlen,
   output logic              arvalid,
   input  logic              arready,
   output logic [3:0]        arid,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic [3:0]        arcache,
   output logic              arlock,
   output logic [2:0]        arprot,
   output logic [3:0]        arqos,
   output logic [3:0]        arregion,
   output logic [DW-1:0]     wdata,
   output logic [DW/8-1:0]   wstrb,
   output logic              wlast,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   input  logic [DW-1:0]     rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready
);
   localparam int BPB = DW / 8;
   localparam int SZ  = $clog2(BPB);
   localparam int OW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t          state_r;
   logic [OW-1:0]   own_r, last_r, win_s;
   logic            win_v_s, rwn_r, stk_r, on_r;
   logic [31:0]     adr_r, rem_r, blen_r, cnt_r, axaddr_r, blen_s, rem_nxt_s, cap_s;
   logic [7:0]      axlen_r;
   logic            avalid_r, wvalid_r, rready_r, bready_r;
   logic [NCH-1:0]  gnt_r, done_r, err_r, own_oh_s;
   logic            hs_s, err_now_s, fin_s, last_beat_s;

   assign own_oh_s    = NCH'(1) << own_r;
   assign last_beat_s = (cnt_r == blen_r - 32'd1);
   assign rem_nxt_s   = rem_r - blen_r;

   // Round-robin search starting one past the previous winner
   always_comb begin
      int idx;
      win_v_s = 1'b0;
      win_s   = {OW{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         idx = (int'(last_r) + 1 + i) % NCH;
         if (!win_v_s && req[idx]) begin
            win_v_s = 1'b1;
            win_s   = OW'(idx);
         end else begin
            win_v_s = win_v_s;
         end
      end
   end

`ifdef NPM_MC_4K_SPLIT_EN
   logic [31:0] to4k_s;
   assign to4k_s = (32'h0000_1000 - {20'h0_0000, adr_r[11:0]}) >> SZ;
`endif

   // Burst size: remaining beats capped by MAXB (and optionally the 4 KB boundary)
   always_comb begin
      cap_s = (rem_r > 32'(MAXB)) ? 32'(MAXB) : rem_r;
`ifdef NPM_MC_4K_SPLIT_EN
      if (to4k_s < cap_s) begin
         blen_s = to4k_s;
      end else begin
         blen_s = cap_s;
      end
`else
      blen_s = cap_s;
`endif
   end

   // Handshake, per-beat error and end-of-burst detection
   always_comb begin
      hs_s      = 1'b0;
      err_now_s = 1'b0;
      fin_s     = 1'b0;
      case (state_r)
         DATA: begin
            if (rwn_r) begin
               hs_s      = rready_r & rvalid;
               err_now_s = hs_s & ((rresp != 2'b00) | (rlast != last_beat_s));
            end else begin
               hs_s      = wvalid_r & wready;
            end
            fin_s = hs_s & last_beat_s & rwn_r;
         end
         RESP: begin
            fin_s     = bvalid;
            err_now_s = bvalid & (bresp != 2'b00);
         end
         default: begin
            hs_s = 1'b0;
         end
      endcase
   end

   // Main sequencer: arbitration, address/data/response phases, completion
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r  <= IDLE;
         own_r    <= {OW{1'b0}};
         last_r   <= OW'(NCH - 1);
         rwn_r    <= 1'b0;
         stk_r    <= 1'b0;
         on_r     <= 1'b0;
         adr_r    <= 32'd0;
         rem_r    <= 32'd0;
         blen_r   <= 32'd0;
         cnt_r    <= 32'd0;
         axaddr_r <= 32'd0;
         axlen_r  <= 8'd0;
         avalid_r <= 1'b0;
         wvalid_r <= 1'b0;
         rready_r <= 1'b0;
         bready_r <= 1'b0;
         gnt_r    <= {NCH{1'b0}};
         done_r   <= {NCH{1'b0}};
         err_r    <= {NCH{1'b0}};
      end else begin
         on_r   <= 1'b1;
         gnt_r  <= {NCH{1'b0}};
         done_r <= {NCH{1'b0}};
         err_r  <= {NCH{1'b0}};
         if (err_now_s) stk_r <= 1'b1;
         case (state_r)
            IDLE: begin
               if (win_v_s) begin
                  own_r   <= win_s;
                  last_r  <= win_s;
                  rwn_r   <= rwn[win_s];
                  adr_r   <= adr[int'(win_s)*32 +: 32];
                  rem_r   <= len[int'(win_s)*32 +: 32];
                  stk_r   <= 1'b0;
                  gnt_r   <= NCH'(1) << win_s;
                  state_r <= ADDR;
               end
            end
            ADDR: begin
               // First ADDR cycle loads the burst; zero-length jobs finish here
               if (!avalid_r) begin
                  if (rem_r == 32'd0) begin
                     done_r  <= own_oh_s;
                     err_r   <= stk_r ? own_oh_s : {NCH{1'b0}};
                     state_r <= IDLE;
                  end else begin
                     avalid_r <= 1'b1;
                     axaddr_r <= adr_r;
                     axlen_r  <= 8'(blen_s - 32'd1);
                     blen_r   <= blen_s;
                     cnt_r    <= 32'd0;
                  end
               end else if (rwn_r ? arready : awready) begin
                  avalid_r <= 1'b0;
                  state_r  <= DATA;
                  if (rwn_r) rready_r <= 1'b1;
                  else       wvalid_r <= 1'b1;
               end
            end
            DATA: begin
               if (hs_s) begin
                  cnt_r <= cnt_r + 32'd1;
                  if (last_beat_s) begin
                     if (rwn_r) begin
                        rready_r <= 1'b0;
                     end else begin
                        wvalid_r <= 1'b0;
                        bready_r <= 1'b1;
                        state_r  <= RESP;
                     end
                  end
               end
            end
            RESP: begin
               if (bvalid) bready_r <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
         if (fin_s) begin
            adr_r <= adr_r + blen_r * 32'(BPB);
            rem_r <= rem_nxt_s;
            if (rem_nxt_s != 32'd0) begin
               state_r <= ADDR;
            end else begin
               done_r  <= own_oh_s;
               err_r   <= (stk_r | err_now_s) ? own_oh_s : {NCH{1'b0}};
               state_r <= IDLE;
            end
         end
      end
   end

   assign gnt     = gnt_r;
   assign done    = done_r;
   assign err     = err_r;
   assign ack     = hs_s ? own_oh_s : {NCH{1'b0}};
   assign rdt     = on_r ? rdata : {DW{1'b0}};
   assign awaddr  = axaddr_r;
   assign araddr  = axaddr_r;
   assign awlen   = axlen_r;
   assign arlen   = axlen_r;
   assign awvalid = avalid_r & ~rwn_r;
   assign arvalid = avalid_r & rwn_r;
   assign wvalid  = wvalid_r;
   assign wdata   = wvalid_r ? wdt[int'(own_r)*DW +: DW] : {DW{1'b0}};
   assign wlast   = wvalid_r & last_beat_s;
   assign wstrb   = on_r ? {(DW/8){1'b1}} : {(DW/8){1'b0}};
   assign bready  = bready_r;
   assign rready  = rready_r;
   // Fixed AXI attributes, held at zero while in reset
   assign awid     = 4'h0;
   assign arid     = 4'h0;
   assign awsize   = on_r ? 3'(SZ) : 3'd0;
   assign arsize   = on_r ? 3'(SZ) : 3'd0;
   assign awburst  = on_r ? 2'b01 : 2'b00;
   assign arburst  = on_r ? 2'b01 : 2'b00;
   assign awcache  = on_r ? 4'b0010 : 4'b0000;
   assign arcache  = on_r ? 4'b0010 : 4'b0000;
   assign awlock   = 1'b0;
   assign arlock   = 1'b0;
   assign awprot   = 3'b000;
   assign arprot   = 3'b000;
   assign awqos    = 4'h0;
   assign arqos    = 4'h0;
   assign awregion = 4'h0;
   assign arregion = 4'h0;
endmodule

// File: tb/tb_npm_mc.sv
// Directed self-checking bench for npm_mc with a small AXI slave responder.
module tb_npm_mc;
   localparam int NCH = 4;
   localparam int DW  = 64;
   localparam logic [63:0] WPAT = 64'hD000_0000_0000_0000;
   localparam logic [63:0] RPAT = 64'hA000_0000_0000_0000;

   logic clk = 1'b0;
   logic rstn;
   logic [NCH-1:0] req, rwn, gnt, ack, done, err;
   logic [32*NCH-1:0] adr, len;
   logic [DW*NCH-1:0] wdt;
   logic [DW-1:0] rdt, wdata, rdata;
   logic [31:0] awaddr, araddr;
   logic [7:0] awlen, arlen;
   logic awvalid, arvalid, awready, arready, wlast, wvalid, wready, bvalid, bready;
   logic rlast, rvalid, rready, awlock, arlock;
   logic [3:0] awid, arid, awcache, arcache, awqos, arqos, awregion, arregion;
   logic [2:0] awsize, arsize, awprot, arprot;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic [DW/8-1:0] wstrb;

   npm_mc #(.NCH(NCH), .DW(DW), .MAXB(256)) dut (
      .clk(clk), .rstn(rstn), .req(req), .rwn(rwn), .adr(adr), .len(len), .wdt(wdt),
      .gnt(gnt), .ack(ack), .done(done), .err(err), .rdt(rdt),
      .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .awid(awid), .awsize(awsize), .awburst(awburst), .awcache(awcache),
      .awlock(awlock), .awprot(awprot), .awqos(awqos), .awregion(awregion),
      .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .arid(arid), .arsize(arsize), .arburst(arburst), .arcache(arcache),
      .arlock(arlock), .arprot(arprot), .arqos(arqos), .arregion(arregion),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;
   int cyc = 0, ack_cnt, done_cnt, err_cnt, errdone_cnt, own_bad, wlast_bad, wdata_bad, rdt_bad;
   int gnt_cyc, done_cyc, last_own, cur_wlen, wb, pend_rd, rd_left, rd_glob, err_beat;
   logic [NCH-1:0] last_gnt;
   logic ar_fire, r_fire, w_fire, w_last_fire, b_fire;
   int gq[$];
   int b_len[$];
   logic [31:0] b_adr[$];
   int rr_exp[5] = '{0, 1, 2, 3, 0};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      ack_cnt = 0; done_cnt = 0; err_cnt = 0; errdone_cnt = 0; own_bad = 0;
      wlast_bad = 0; wdata_bad = 0; rdt_bad = 0; gnt_cyc = 0; done_cyc = -100;
      rd_glob = 0; err_beat = -1;
      gq.delete(); b_len.delete(); b_adr.delete();
   endtask

   task automatic set_ch(input int c, input logic rw, input logic [31:0] a, input logic [31:0] l);
      rwn[c] = rw;
      adr[c*32 +: 32] = a;
      len[c*32 +: 32] = l;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(negedge clk); #2; end
   endtask

   task automatic wait_done(input int n, input int lim);
      int k = 0;
      while (done_cnt < n && k < lim) begin @(negedge clk); #2; k++; end
      chk("done_wait", done_cnt, n);
   endtask

   // Monitor: observe handshakes that complete at the next rising edge
   always @(negedge clk) begin
      cyc++;
      ar_fire = 1'b0; r_fire = 1'b0; w_fire = 1'b0; w_last_fire = 1'b0; b_fire = 1'b0;
      if (rstn) begin
         if (gnt != '0) begin
            for (int i = 0; i < NCH; i++) if (gnt[i]) begin gq.push_back(i); last_own = i; end
            last_gnt = gnt; gnt_cyc = cyc;
         end
         ack_cnt += $countones(ack);
         if (done != '0) begin
            done_cnt++; done_cyc = cyc;
            if (done != last_gnt) own_bad++;
         end
         if (err != '0) begin err_cnt++; if (err == done) errdone_cnt++; end
         if (awvalid && awready) begin
            b_adr.push_back(awaddr); b_len.push_back(int'(awlen) + 1);
            cur_wlen = int'(awlen) + 1; wb = 0;
         end
         if (arvalid && arready) begin
            ar_fire = 1'b1; pend_rd = int'(arlen) + 1;
            b_adr.push_back(araddr); b_len.push_back(int'(arlen) + 1);
         end
         if (wvalid && wready) begin
            w_fire = 1'b1; w_last_fire = wlast;
            if (wlast != (wb == cur_wlen - 1)) wlast_bad++;
            if (wdata != (WPAT | 64'(last_own))) wdata_bad++;
            wb++;
         end
         if (rvalid && rready) begin r_fire = 1'b1; if (rdt != rdata) rdt_bad++; end
         if (bvalid && bready) b_fire = 1'b1;
      end
   end

   // Slave: update read beats and write response just after each rising edge
   always @(posedge clk) begin
      #1;
      if (!rstn) begin
         rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; bvalid = 1'b0;
      end else begin
         if (ar_fire || r_fire) begin
            if (ar_fire) rd_left = pend_rd;
            else begin rd_left--; rd_glob++; end
            if (rd_left == 0) begin
               rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            end else begin
               rvalid = 1'b1; rdata = RPAT + 64'(rd_glob); rlast = (rd_left == 1);
               rresp = (rd_glob == err_beat) ? 2'b10 : 2'b00;
            end
         end
         if (w_fire && w_last_fire) bvalid = 1'b1;
         else if (b_fire) bvalid = 1'b0;
      end
   end

   initial begin
      rstn = 1'b1; req = '0; rwn = '0; adr = '0; len = '0;
      awready = 1'b1; arready = 1'b1; wready = 1'b1; bresp = 2'b00; bvalid = 1'b0;
      rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
      for (int c = 0; c < NCH; c++) wdt[c*DW +: DW] = WPAT | 64'(c);
      clr();
      #1 rstn = 1'b0;
      #1 chk("reset_out", {gnt, ack, done, err, awvalid, arvalid, wvalid, wlast, bready, rready,
                           awsize, awburst, awcache, wstrb}, 64'd0);
      idle(2); rstn = 1'b1; idle(1);
      chk("axi_const", {awsize, awburst, awcache, arsize, arburst, arcache, wstrb, awid, arid,
                        awlock, awprot, awqos, awregion},
          {3'd3, 2'd1, 4'd2, 3'd3, 2'd1, 4'd2, 8'hFF, 4'd0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0});

      // Round robin with all channels requesting single-beat reads
      clr();
      for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, 32'h100 * c, 32'd1);
      req = 4'b1111;
      wait_done(5, 200);
      req = '0; idle(3);
      chk("rr_count", gq.size(), 5);
      for (int i = 0; i < 5; i++) chk("rr_order", (i < gq.size()) ? gq[i] : -1, rr_exp[i]);
      chk("rr_done_owner", own_bad, 0);

      // Long write split into MAXB bursts
      clr();
      set_ch(1, 1'b0, 32'h1000, 32'd600);
      req = 4'b0010;
      wait_done(1, 2000);
      req = '0; idle(3);
      chk("wr_nburst", b_len.size(), 3);
      chk("wr_b0", (b_len.size() > 0) ? {b_adr[0], 32'(b_len[0])} : '1, {32'h1000, 32'd256});
      chk("wr_b1", (b_len.size() > 1) ? {b_adr[1], 32'(b_len[1])} : '1, {32'h1800, 32'd256});
      chk("wr_b2", (b_len.size() > 2) ? {b_adr[2], 32'(b_len[2])} : '1, {32'h2000, 32'd88});
      chk("wr_ack", ack_cnt, 600);
      chk("wr_err", err_cnt, 0);
      chk("wr_wlast", wlast_bad, 0);
      chk("wr_wdata", wdata_bad, 0);

      // Read with SLVERR on one beat
      clr();
      err_beat = 3;
      set_ch(2, 1'b1, 32'h2000_0000, 32'd10);
      req = 4'b0100;
      wait_done(1, 200);
      req = '0; idle(3);
      chk("rd_ack", ack_cnt, 10);
      chk("rd_err", err_cnt, 1);
      chk("rd_err_with_done", errdone_cnt, 1);
      chk("rd_rdt", rdt_bad, 0);
      chk("rd_blen", (b_len.size() > 0) ? b_len[0] : -1, 10);

      // Zero-length request
      clr();
      set_ch(3, 1'b0, 32'h3000, 32'd0);
      req = 4'b1000;
      wait_done(1, 50);
      req = '0; idle(3);
      chk("len0_bursts", b_len.size(), 0);
      chk("len0_gap", done_cyc - gnt_cyc, 1);
      chk("len0_ack", ack_cnt, 0);

      // Burst crossing a 4 KB boundary
      clr();
      set_ch(0, 1'b1, 32'h0FF0, 32'd8);
      req = 4'b0001;
      wait_done(1, 100);
      req = '0; idle(3);
      chk("x4k_ack", ack_cnt, 8);
`ifdef NPM_MC_4K_SPLIT_EN
      chk("x4k_nburst", b_len.size(), 2);
      chk("x4k_b0", (b_len.size() > 0) ? b_len[0] : -1, 2);
      chk("x4k_b1", (b_len.size() > 1) ? {b_adr[1], 32'(b_len[1])} : '1, {32'h1000, 32'd6});
`else
      chk("x4k_nburst", b_len.size(), 1);
      chk("x4k_b0", (b_len.size() > 0) ? b_len[0] : -1, 8);
`endif

      // Reset in the middle of a write data phase
      clr();
      set_ch(1, 1'b0, 32'h4000, 32'd20);
      req = 4'b0010;
      for (int k = 0; k < 50 && !wvalid; k++) idle(1);
      chk("mid_wr_started", wvalid, 1'b1);
      rstn = 1'b0; req = '0;
      #1 chk("mid_rst_out", {gnt, ack, done, err, awvalid, arvalid, wvalid, wlast, bready, rready,
                            |wdata, |awaddr, |awlen}, 64'd0);
      rvalid = 1'b0; bvalid = 1'b0;
      idle(2); rstn = 1'b1; idle(1);
      clr();
      set_ch(1, 1'b1, 32'h5000, 32'd1);
      set_ch(3, 1'b1, 32'h6000, 32'd1);
      req = 4'b1010;
      wait_done(2, 100);
      req = '0; idle(3);
      chk("post_rst_g0", (gq.size() > 0) ? gq[0] : -1, 1);
      chk("post_rst_g1", (gq.size() > 1) ? gq[1] : -1, 3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/npm_mc.md
NPM_MC -- requirements
Module: npm_mc

Interface
REQ-001 SHALL have parameter NCH, default 4: number of NP-core requester channels, 1..8.
REQ-002 SHALL have parameter DW, default 64: AXI and core data width in bits, one of 32/64/128.
REQ-003 SHALL have parameter MAXB, default 256: maximum beats per AXI burst, 1..256.
REQ-004 SHALL have ports: clk  input  1  clock; rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports: req/rwn  input  NCH  per-channel request / read-not-write.
REQ-006 SHALL have ports: adr/len  input  32*NCH  per-channel byte start address / transfer length in beats.
REQ-007 SHALL have ports: wdt  input  DW*NCH  per-channel write data.
REQ-008 SHALL have ports: gnt/ack/done/err  output  NCH  grant pulse / beat strobe / completion pulse / error pulse.
REQ-009 SHALL have port: rdt  output  DW  read data, shared by all channels.
REQ-010 SHALL have AXI4 master ports: awaddr/araddr 32 out; awlen/arlen 8 out; awvalid/arvalid out; awready/arready in; wdata DW out; wstrb DW/8 out; wlast/wvalid out; wready in; bresp 2 in; bvalid in; bready out; rdata DW in; rresp 2 in; rlast/rvalid in; rready out.
REQ-011 SHALL drive the AXI constants: id 0, size log2(DW/8), burst INCR, cache 4'b0010, wstrb all ones, lock/prot/qos/region 0.

Function
REQ-012 SHALL arbitrate round-robin, only in IDLE: the winner is the first asserted req searching upward, with wrap, from the channel after the previous winner.
REQ-013 SHALL latch the winner's rwn, adr and len in the winning cycle, and SHALL pulse gnt[winner] for exactly one cycle on the next clock.
REQ-014 SHALL sequence states IDLE -> ADDR -> DATA -> RESP (write only) -> ADDR or IDLE.
REQ-015 SHALL size each burst as min(remaining len, MAXB) beats, and SHALL drive awlen/arlen as that value minus 1.
REQ-016 ADDR SHALL hold awvalid (write) or arvalid (read) until the handshake, then enter DATA.
REQ-017 DATA SHALL hold wvalid with wdata = wdt[owner] (write) or rready (read); each handshake SHALL pulse ack[owner] in the same cycle; rdt SHALL equal rdata combinationally.
REQ-018 A beat counter SHALL end the burst; wlast SHALL be asserted on the counted final beat; an rlast disagreeing with the counter SHALL flag an error.
REQ-019 A write burst SHALL go to RESP and hold bready until bvalid.
REQ-020 After each burst: with beats remaining, address SHALL advance by beats*DW/8 and the block SHALL return to ADDR; otherwise it SHALL pulse done[owner] for one cycle and enter IDLE.
REQ-021 SHALL allow a new grant on the cycle after IDLE is entered.
REQ-022 A nonzero bresp/rresp or an rlast mismatch SHALL be made sticky and reported as err[owner] pulsed together with done; the transfer SHALL still run to completion.
REQ-023 len=0 SHALL generate no AXI traffic and SHALL pulse done one cycle after gnt.
REQ-024 req deasserting after grant SHALL be ignored; req and rwn SHALL NOT be sampled outside IDLE.
REQ-025 Address and length arithmetic SHALL be 32-bit and wrap modulo 2^32.

Reset
REQ-026 rstn low SHALL force IDLE, clear the round-robin pointer (channel 0 searched first), and drive all outputs 0 asynchronously, including mid-burst.

Configuration
REQ-027 With NPM_MC_4K_SPLIT_EN defined, burst length SHALL be additionally limited to the beats remaining before the next 4 KB address boundary; without it, REQ-015 SHALL apply unchanged.

Verification
REQ-028 req=4'b1111, all len=1, repeated: grants SHALL go 0,1,2,3,0; each done SHALL follow its own burst.
REQ-029 Write, len=600, MAXB=256, adr=0x1000: bursts SHALL be 256/256/88 at 0x1000/0x1800/0x2000; 600 ack; one done.
REQ-030 Read, rresp=SLVERR on beat 3 of 10: all 10 ack; done and err pulsed together once.
REQ-031 NPM_MC_4K_SPLIT_EN defined, DW=64, adr=0x0FF0, len=8: bursts SHALL be 2 and 6 beats.
REQ-032 rstn low in DATA of a write: wvalid and all outputs 0 immediately; the next request SHALL be granted normally.
